// File: rtl/pwm_capture_pkg.sv
// Shared types and limits for the PWM capture block and its input synchroniser.
package pwm_capture_pkg;

    localparam int unsigned MIN_SYNC_STAGES = 2;

    typedef enum logic {
        IDLE,
        MEASURE
    } cap_state_t;

endpackage : pwm_capture_pkg

// File: rtl/pwm_capture_if.sv
// Result bus of pwm_capture: measured period/high time plus event pulses.
interface pwm_capture_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_time;
    logic             valid;
    logic             timeout;
    logic             level;

    modport master (
        output period,
        output high_time,
        output valid,
        output timeout,
        output level
    );

    modport slave (
        input period,
        input high_time,
        input valid,
        input timeout,
        input level
    );
endinterface : pwm_capture_if

// File: rtl/pwm_capture_sync_rise_detect.sv
// Multi-flop synchroniser for an async input with a registered rising-edge strobe.
// q is the delayed synchronised level so that it lines up with rise.
module sync_rise_detect
    import pwm_capture_pkg::*;
#(
    parameter int unsigned STAGES = MIN_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);

    // Never fewer than two flops on an asynchronous input.
    localparam int unsigned N = (STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : STAGES;

    logic [N-1:0] sync_q;
    logic         s;

    assign s = sync_q[N-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            q      <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[N-2:0], d};
            q      <= s;
            rise   <= s & ~q;
        end
    end

endmodule : sync_rise_detect

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous waveform in local clk cycles,
// with a timeout that reports the stuck level when no rising edge arrives.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          sig_in,
    pwm_capture_if.master res
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    cap_state_t       state, state_n;
    logic [WIDTH-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] hcnt, hcnt_n;
    logic [WIDTH-1:0] period_q, period_n;
    logic [WIDTH-1:0] high_q, high_n;
    logic             valid_q, valid_n;
    logic             timeout_q, timeout_n;
    logic             level_q, level_n;
    logic             s;
    logic             rise;

    sync_rise_detect #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (sig_in),
        .q    (s),
        .rise (rise)
    );

    // State, counters and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            hcnt      <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            level_q   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            hcnt      <= hcnt_n;
            period_q  <= period_n;
            high_q    <= high_n;
            valid_q   <= valid_n;
            timeout_q <= timeout_n;
            level_q   <= level_n;
        end
    end

    // Next state: the rise cycle itself counts as the first cycle (and first high
    // cycle) of the new period, so both counters reload to one.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        hcnt_n    = hcnt;
        period_n  = period_q;
        high_n    = high_q;
        valid_n   = 1'b0;
        timeout_n = 1'b0;
        level_n   = level_q;

        if (!enable) begin
            state_n = IDLE;
            cnt_n   = '0;
            hcnt_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_n  = '0;
                    hcnt_n = '0;
                    if (rise) begin
                        state_n = MEASURE;
                        cnt_n   = CNT_ONE;
                        hcnt_n  = CNT_ONE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_n = cnt;
                        high_n   = hcnt;
                        valid_n  = 1'b1;
                        cnt_n    = CNT_ONE;
                        hcnt_n   = CNT_ONE;
                    end else if (cnt == CNT_MAX) begin
                        timeout_n = 1'b1;
                        level_n   = s;
                        state_n   = IDLE;
                        cnt_n     = '0;
                        hcnt_n    = '0;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                        if (s && (hcnt != CNT_MAX)) begin
                            hcnt_n = hcnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    hcnt_n  = '0;
                end
            endcase
        end
    end

    assign res.period    = period_q;
    assign res.high_time = high_q;
    assign res.valid     = valid_q;
    assign res.timeout   = timeout_q;
    assign res.level     = level_q;

endmodule : pwm_capture
